dct_mac_sequencer: RTL and testbench

Sequencer for one DCT unit's multiply-accumulate datapath in the jpeg_encoder fdct path. It buffers one 8-sample row. For each of the 8 output coefficients u = 0..7 it drives the MAC unit through clear, eight accumulate steps, pipeline drain and result-register capture. It then presents the captured coefficient index downstream with a valid/ready handshake. It sits between the row source and the macu instance. Its `res_en` output is the enable of the macu result register.

---
 rtl/dct_mac_sequencer_if.sv | 32 +++
 rtl/dct_mac_sequencer.sv | 94 +++++++++
 tb/tb_dct_mac_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_mac_sequencer_if.sv
// Handshake and MAC-control bundle between the row source, the sequencer,
// the macu instance and the downstream consumer.
interface dct_mac_sequencer_if #(
  parameter int unsigned DW = 8
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          mac_clr;
  logic          mac_en;
  logic [DW-1:0] mac_x;
  logic [2:0]    coef_u;
  logic [2:0]    coef_x;
  logic          res_en;
  logic          out_valid;
  logic [2:0]    out_u;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  modport master (
    input  din_valid, din, out_ready,
    output din_ready, mac_clr, mac_en, mac_x, coef_u, coef_x,
           res_en, out_valid, out_u, out_last, busy
  );

  modport slave (
    output din_valid, din, out_ready,
    input  din_ready, mac_clr, mac_en, mac_x, coef_u, coef_x,
           res_en, out_valid, out_u, out_last, busy
  );
endinterface

// File: rtl/dct_mac_sequencer.sv
// Buffers one 8-sample row and steps the macu through clear, 8 accumulates,
// drain and capture for each coefficient u, then hands u downstream.
module dct_mac_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  dct_mac_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    CAP   = 3'd4,
    OUT   = 3'd5
  } state_t;

  localparam logic [1:0] DRAIN_INIT = (MAC_LAT > 0) ? 2'(MAC_LAT - 1) : 2'd0;

  state_t        state;
  logic [2:0]    x;
  logic [2:0]    u;
  logic [1:0]    dcnt;
  logic [DW-1:0] row [8];

  // Row buffer has no reset: it is only read after a complete row is written.
  always_ff @(posedge clk) begin
    if (!rst && ena && state == LOAD && bus.din_valid)
      row[x] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      x     <= '0;
      u     <= '0;
      dcnt  <= '0;
    end else if (ena) begin
      case (state)
        LOAD: begin
          if (bus.din_valid) begin
            x <= x + 3'd1;
            if (x == 3'd7) begin
              u     <= '0;
              state <= CLR;
            end
          end
        end
        CLR: state <= MAC;
        MAC: begin
          x <= x + 3'd1;
          if (x == 3'd7) begin
            dcnt  <= DRAIN_INIT;
            state <= (MAC_LAT > 0) ? DRAIN : CAP;
          end
        end
        DRAIN: begin
          if (dcnt == '0) state <= CAP;
          else            dcnt  <= dcnt - 2'd1;
        end
        CAP: state <= OUT;
        OUT: begin
          if (bus.out_ready) begin
            if (u == 3'd7) begin
              state <= LOAD;
            end else begin
              u     <= u + 3'd1;
              state <= CLR;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Strobes are gated by ena so a frozen cycle never reaches the macu.
  assign bus.din_ready = ena && (state == LOAD);
  assign bus.mac_clr   = ena && (state == CLR);
  assign bus.mac_en    = ena && (state == MAC);
  assign bus.res_en    = ena && (state == CAP);
  assign bus.mac_x     = (state == MAC) ? row[x] : '0;
  assign bus.coef_x    = (state == MAC) ? x : '0;
  assign bus.coef_u    = u;
  assign bus.out_valid = (state == OUT);
  assign bus.out_u     = u;
  assign bus.out_last  = (state == OUT) && (u == 3'd7);
  assign bus.busy      = (state != LOAD);

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Scoreboard bench: stimulus queues expected MAC steps, results and row times;
// one negedge monitor checks three instances (MAC_LAT = 1, 0, 3).
module tb_dct_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic m_rst  = 1'b1;
  logic m_ena  = 1'b1;
  logic sw_rst = 1'b1;

  dct_mac_sequencer_if #(.DW(8)) m_if ();
  dct_mac_sequencer_if #(.DW(8)) z_if ();
  dct_mac_sequencer_if #(.DW(8)) t_if ();

  dct_mac_sequencer #(.DW(8), .MAC_LAT(1)) u_main (
    .clk(clk), .rst(m_rst), .ena(m_ena), .bus(m_if.master));
  dct_mac_sequencer #(.DW(8), .MAC_LAT(0)) u_lat0 (
    .clk(clk), .rst(sw_rst), .ena(1'b1), .bus(z_if.master));
  dct_mac_sequencer #(.DW(8), .MAC_LAT(3)) u_lat3 (
    .clk(clk), .rst(sw_rst), .ena(1'b1), .bus(t_if.master));

  typedef logic signed [7:0] row_t [8];
  typedef struct packed { logic [2:0] u; logic [2:0] x; logic signed [7:0] s; } mac_e;
  typedef struct packed { logic [2:0] u; logic signed [15:0] r; logic [7:0] hold; } out_e;

  mac_e q_mac [3][$];
  out_e q_out [3][$];
  int   q_row [3][$];

  int ld [3], t_start [3], gap [3], since_clr [3], acc [3], res [3], hold [3];
  bit prev_busy [3], was_rst [3], exp_clr [3], exp_dr0 [3];

  int    total = 0, bad = 0, cyc = 0;
  int    to_cnt = 0, to_seen = 0, fin_req = 0, fin_seen = 0;
  string to_what = "";

  row_t ra, rb, rc;

  task automatic chk(input string nm, input int i, input logic signed [31:0] a,
                     input logic signed [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", nm, i, a, e);
    end
  endtask

  task automatic mon(input int i, input int lat, input logic r, e, dv, dr, clr, men,
                     input logic signed [7:0] mx, input logic [2:0] cu, cx,
                     input logic ren, ov, input logic [2:0] ou, input logic ol, ordy, bsy);
    mac_e me;
    out_e oe;
    if (r) begin
      q_mac[i].delete(); q_out[i].delete(); q_row[i].delete();
      ld[i] = 0; acc[i] = 0; hold[i] = 0; prev_busy[i] = 0;
      was_rst[i] = 1; exp_clr[i] = 0; exp_dr0[i] = 0;
      return;
    end
    if (was_rst[i]) begin
      was_rst[i] = 0;
      chk("rst_busy", i, bsy, 0);
      chk("rst_out_valid", i, ov, 0);
      chk("rst_res_en", i, ren, 0);
      chk("rst_strobes", i, {clr, men}, 0);
      chk("rst_out_u", i, ou, 0);
      chk("rst_coef", i, {cu, cx}, 0);
      chk("rst_out_last", i, ol, 0);
      if (e) chk("rst_din_ready", i, dr, 1);
    end
    if (!e) begin
      chk("ena0_strobes", i, {dr, clr, men, ren}, 0);
      return;
    end
    gap[i]++;
    since_clr[i]++;
    if (exp_dr0[i]) begin
      chk("din_ready_drop", i, dr, 0);
      chk("clr_after_load", i, clr, 1);
      exp_dr0[i] = 0;
    end
    if (exp_clr[i]) begin
      chk("clr_after_ack", i, clr, 1);
      exp_clr[i] = 0;
    end
    if (dv && dr) begin
      if (ld[i] == 0) t_start[i] = cyc;
      ld[i] = (ld[i] == 7) ? 0 : ld[i] + 1;
      if (ld[i] == 0) exp_dr0[i] = 1;
    end
    if (clr) begin
      acc[i] = 0;
      since_clr[i] = 0;
    end
    if (men) begin
      gap[i] = 0;
      if (q_mac[i].size() == 0) chk("mac_unexpected", i, men, 0);
      else begin
        me = q_mac[i].pop_front();
        chk("coef_u", i, cu, me.u);
        chk("coef_x", i, cx, me.x);
        chk("mac_x", i, mx, me.s);
        if (cu == cx) acc[i] += int'(mx);
      end
    end
    if (ren) begin
      chk("res_latency", i, gap[i], lat + 1);
      chk("clr_to_res", i, since_clr[i], lat + 9);
      res[i] = acc[i];
    end
    if (ov) begin
      hold[i]++;
      chk("strobes_in_out", i, {clr, men, ren}, 0);
      if (q_out[i].size() == 0) chk("out_unexpected", i, ov, 0);
      else begin
        oe = q_out[i][0];
        chk("out_u", i, ou, oe.u);
        chk("out_last", i, ol, (oe.u == 3'd7));
        if (ordy) begin
          void'(q_out[i].pop_front());
          chk("result", i, res[i], oe.r);
          chk("out_hold", i, hold[i], oe.hold);
          hold[i] = 0;
          if (oe.u != 3'd7) exp_clr[i] = 1;
        end
      end
    end
    if (prev_busy[i] && !bsy) begin
      if (q_row[i].size() == 0) chk("row_unexpected", i, bsy, 1);
      else chk("row_time", i, cyc - t_start[i], q_row[i].pop_front());
    end
    prev_busy[i] = bsy;
  endtask

  always @(negedge clk) begin
    cyc++;
    while (to_seen != to_cnt) begin
      to_seen++;
      total++;
      bad++;
      $display("FAIL timeout %s: got no event want event", to_what);
    end
    mon(0, 1, m_rst, m_ena, m_if.din_valid, m_if.din_ready, m_if.mac_clr, m_if.mac_en,
        m_if.mac_x, m_if.coef_u, m_if.coef_x, m_if.res_en, m_if.out_valid, m_if.out_u,
        m_if.out_last, m_if.out_ready, m_if.busy);
    mon(1, 0, sw_rst, 1'b1, z_if.din_valid, z_if.din_ready, z_if.mac_clr, z_if.mac_en,
        z_if.mac_x, z_if.coef_u, z_if.coef_x, z_if.res_en, z_if.out_valid, z_if.out_u,
        z_if.out_last, z_if.out_ready, z_if.busy);
    mon(2, 3, sw_rst, 1'b1, t_if.din_valid, t_if.din_ready, t_if.mac_clr, t_if.mac_en,
        t_if.mac_x, t_if.coef_u, t_if.coef_x, t_if.res_en, t_if.out_valid, t_if.out_u,
        t_if.out_last, t_if.out_ready, t_if.busy);
    if (fin_seen != fin_req) begin
      fin_seen = fin_req;
      for (int i = 0; i < 3; i++) begin
        chk("left_mac", i, q_mac[i].size(), 0);
        chk("left_out", i, q_out[i].size(), 0);
        chk("left_row", i, q_row[i].size(), 0);
      end
    end
  end

  // Identity coefficient table: captured result for u is sample u.
  task automatic push_exp(input int i, input row_t r, input int rt, input int stall_u);
    mac_e me;
    out_e oe;
    for (int u = 0; u < 8; u++) begin
      for (int x = 0; x < 8; x++) begin
        me.u = 3'(u); me.x = 3'(x); me.s = r[x];
        q_mac[i].push_back(me);
      end
      oe.u = 3'(u); oe.r = 16'(r[u]); oe.hold = (u == stall_u) ? 8'd6 : 8'd1;
      q_out[i].push_back(oe);
    end
    q_row[i].push_back(rt);
  endtask

  task automatic load(input row_t rm, input row_t rs, input bit sw);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      m_if.din_valid = 1'b1; m_if.din = rm[k];
      if (sw) begin
        z_if.din_valid = 1'b1; z_if.din = rs[k];
        t_if.din_valid = 1'b1; t_if.din = rs[k];
      end
    end
    @(posedge clk); #1;
    m_if.din_valid = 1'b0; z_if.din_valid = 1'b0; t_if.din_valid = 1'b0;
  endtask

  task automatic wait_main_mac(input int u, input int x);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(m_if.mac_en && m_if.coef_u == 3'(u) && m_if.coef_x == 3'(x)) && n < 2000);
    if (n >= 2000) begin to_what = "wait_mac"; to_cnt++; end
  endtask

  task automatic wait_main_ov();
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_if.out_valid && n < 2000);
    if (n >= 2000) begin to_what = "wait_out_valid"; to_cnt++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((m_if.busy || z_if.busy || t_if.busy) && n < 2000);
    if (n >= 2000) begin to_what = "wait_idle"; to_cnt++; end
  endtask

  initial begin
    m_if.din_valid = 1'b0; m_if.din = '0; m_if.out_ready = 1'b1;
    z_if.din_valid = 1'b0; z_if.din = '0; z_if.out_ready = 1'b1;
    t_if.din_valid = 1'b0; t_if.din = '0; t_if.out_ready = 1'b1;
    ra = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    rb = '{-8'sd128, 8'sd127, 8'sd0, 8'sd5, -8'sd1, 8'sd64, 8'sd3, 8'sd2};
    rc = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, -8'sd60, 8'sd70, -8'sd80};
    repeat (3) @(posedge clk);
    #1; m_rst = 1'b0; sw_rst = 1'b0;

    // Plain row on all three; latency sweep rows take 96 and 120 cycles.
    push_exp(0, ra, 104, 8);
    push_exp(1, rb, 96, 8);
    push_exp(2, rb, 120, 8);
    load(ra, rb, 1'b1);
    wait_idle();

    // Backpressure: out_ready low for 5 cycles while u = 3 is presented.
    push_exp(0, rb, 109, 3);
    load(rb, rb, 1'b0);
    wait_main_mac(3, 7);
    @(posedge clk); #1; m_if.out_ready = 1'b0;
    wait_main_ov();
    repeat (5) @(posedge clk);
    #1; m_if.out_ready = 1'b1;
    wait_idle();

    // ena low for 3 cycles with x = 4 pending at u = 1.
    push_exp(0, rc, 107, 8);
    load(rc, rb, 1'b0);
    wait_main_mac(1, 3);
    @(posedge clk); #1; m_ena = 1'b0;
    repeat (3) @(posedge clk);
    #1; m_ena = 1'b1;
    wait_idle();

    // Reset during DRAIN of u = 2; pending expectations are discarded.
    push_exp(0, ra, 104, 8);
    load(ra, rb, 1'b0);
    wait_main_mac(2, 7);
    @(posedge clk); #1; m_rst = 1'b1;
    @(posedge clk); #1; m_rst = 1'b0;
    repeat (2) @(posedge clk);
    wait_idle();

    push_exp(0, rb, 104, 8);
    load(rb, rb, 1'b0);
    wait_idle();

    #1; fin_req++;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
